// File: rtl/mask_row_scheduler_pkg.sv
// Shared types and constants for the mask row streaming blocks.
package mask_pkg;

  localparam int unsigned ROW_W             = 9;
  localparam int unsigned MASK_W            = 16;
  localparam int unsigned SUB_W             = 8;
  localparam int unsigned NUM_ROWS_DEF      = 320;
  localparam int unsigned WORDS_PER_ROW_DEF = 20;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    ROW_END,
    DONE
  } state_e;

  // Strict-inequality window test; inv flips which rows take upstream data.
  function automatic logic row_in_win(input logic [ROW_W-1:0] row,
                                      input logic [ROW_W-1:0] top,
                                      input logic [ROW_W-1:0] bot,
                                      input logic             inv);
    return ((row > top) && (row < bot)) ^ inv;
  endfunction

endpackage

// File: rtl/mask_row_scheduler_if.sv
// Upstream word handshake plus downstream row-tagged mask stream.
interface mask_row_scheduler_if;
  import mask_pkg::*;

  logic              in_valid;
  logic [MASK_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [MASK_W-1:0] out_data;
  logic [ROW_W-1:0]  out_rowadd;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_rowadd, out_last
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_rowadd, out_last
  );

endinterface

// File: rtl/mask_row_scheduler_out_reg.sv
// Single-entry output register: holds data stable while the sink stalls.
module mask_out_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign s_ready_o = !valid_q || m_ready_i;
  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (s_ready_o) begin
      valid_q <= s_valid_i;
      if (s_valid_i) data_q <= s_data_i;
    end
  end

endmodule

// File: rtl/mask_row_scheduler.sv
// Frame-scoped row/word sequencer for the pixel-array mask stream.
// Optional MASK_INVERT_EN adds cfg_invert to swap window polarity.
module mask_row_scheduler
  import mask_pkg::*;
#(
  parameter int unsigned NUM_ROWS      = NUM_ROWS_DEF,
  parameter int unsigned WORDS_PER_ROW = WORDS_PER_ROW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ROW_W-1:0]     cfg_row_t,
  input  logic [ROW_W-1:0]     cfg_row_b,
  input  logic [SUB_W-1:0]     cfg_num_sub,
  input  logic [MASK_W-1:0]    mstream_default,
`ifdef MASK_INVERT_EN
  input  logic                 cfg_invert,
`endif
  mask_row_scheduler_if.master bus,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned WCNT_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int unsigned PKT_W  = ROW_W + 1 + MASK_W;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);

  state_e             state_q;
  logic [ROW_W-1:0]   row_q;
  logic [WCNT_W-1:0]  word_q;
  logic [SUB_W-1:0]   sub_q;
  logic               win_q;
  logic [ROW_W-1:0]   top_q;
  logic [ROW_W-1:0]   bot_q;
  logic [SUB_W-1:0]   last_sub_q;
  logic [MASK_W-1:0]  dflt_q;
  logic               inv_q;
  logic               busy_q;
  logic               done_q;

  logic               inv_d;
  logic               s_ready;
  logic               push;
  logic               word_last;
  logic [ROW_W-1:0]   row_d;
  logic [PKT_W-1:0]   push_pkt;
  logic [PKT_W-1:0]   out_pkt;

`ifdef MASK_INVERT_EN
  assign inv_d = cfg_invert;
`else
  assign inv_d = 1'b0;
`endif

  assign word_last   = (word_q == LAST_WORD);
  assign row_d       = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
  // Out-of-window rows never wait on upstream; in-window rows stall on in_valid.
  assign push        = (state_q == STREAM) && (win_q ? bus.in_valid : 1'b1) && s_ready;
  assign bus.in_ready = (state_q == STREAM) && win_q && s_ready;
  assign push_pkt    = {row_q, word_last, (win_q ? bus.in_data : dflt_q)};

  assign {bus.out_rowadd, bus.out_last, bus.out_data} = out_pkt;
  assign busy       = busy_q;
  assign frame_done = done_q;

  mask_out_reg #(.W(PKT_W)) u_out_reg (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .s_valid_i (push),
    .s_ready_o (s_ready),
    .s_data_i  (push_pkt),
    .m_valid_o (bus.out_valid),
    .m_ready_i (bus.out_ready),
    .m_data_o  (out_pkt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      word_q     <= '0;
      sub_q      <= '0;
      win_q      <= 1'b0;
      top_q      <= '0;
      bot_q      <= '0;
      last_sub_q <= '0;
      dflt_q     <= '0;
      inv_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse is dropped on purpose.
          if (start && !done_q) begin
            top_q      <= cfg_row_t;
            bot_q      <= cfg_row_b;
            last_sub_q <= (cfg_num_sub == '0) ? '0 : cfg_num_sub - SUB_W'(1);
            dflt_q     <= mstream_default;
            inv_q      <= inv_d;
            busy_q     <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          row_q   <= '0;
          word_q  <= '0;
          sub_q   <= '0;
          win_q   <= row_in_win('0, top_q, bot_q, inv_q);
          state_q <= STREAM;
        end
        STREAM: begin
          if (push) begin
            if (word_last) begin
              word_q  <= '0;
              state_q <= ROW_END;
            end else begin
              word_q <= word_q + WCNT_W'(1);
            end
          end
        end
        ROW_END: begin
          row_q <= row_d;
          win_q <= row_in_win(row_d, top_q, bot_q, inv_q);
          if (row_q == LAST_ROW && sub_q == last_sub_q) begin
            state_q <= DONE;
          end else begin
            if (row_q == LAST_ROW) sub_q <= sub_q + SUB_W'(1);
            state_q <= STREAM;
          end
        end
        DONE: begin
          // Hold until the final word has left the output register.
          if (!bus.out_valid || bus.out_ready) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_row_scheduler.sv
// Randomized bench for mask_row_scheduler against a frame-level word-list model.
module tb_mask_row_scheduler;

  localparam int unsigned NR  = 8;
  localparam int unsigned WPR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  cfg_row_t = '0;
  logic [8:0]  cfg_row_b = '0;
  logic [7:0]  cfg_num_sub = 8'd1;
  logic [15:0] mstream_default = '0;
`ifdef MASK_INVERT_EN
  logic        cfg_invert = 1'b0;
`endif
  logic        busy;
  logic        frame_done;

  mask_row_scheduler_if bus ();

  mask_row_scheduler #(.NUM_ROWS(NR), .WORDS_PER_ROW(WPR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .cfg_row_t       (cfg_row_t),
    .cfg_row_b       (cfg_row_b),
    .cfg_num_sub     (cfg_num_sub),
    .mstream_default (mstream_default),
`ifdef MASK_INVERT_EN
    .cfg_invert      (cfg_invert),
`endif
    .bus             (bus),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Model: the complete expected word list of one frame.
  logic [15:0] exp_data_q[$];
  logic [8:0]  exp_row_q[$];
  logic        exp_last_q[$];
  int unsigned exp_total;
  int unsigned exp_up;

  logic [8:0]  cur_t, cur_b;
  logic [7:0]  cur_ns;
  logic [15:0] cur_def;
  bit          cur_inv = 1'b0;

  // Stimulus/monitor state.
  bit          chk_en = 1'b0;
  int          ready_mode = 0;
  int          valid_pct = 100;
  logic [15:0] up_val = 16'h0001;
  int unsigned up_hs, out_cnt, done_cnt;
  bit          in_ready_seen;
  bit          hold_q = 1'b0;
  logic [25:0] hold_pkt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic build_frame();
    int unsigned nsub;
    int unsigned k;
    bit win;
    nsub = (cur_ns == 0) ? 1 : int'(cur_ns);
    k = 0;
    exp_data_q.delete(); exp_row_q.delete(); exp_last_q.delete();
    for (int unsigned s = 0; s < nsub; s++)
      for (int unsigned r = 0; r < NR; r++)
        for (int unsigned w = 0; w < WPR; w++) begin
          win = ((r > int'(cur_t)) && (r < int'(cur_b))) != cur_inv;
          exp_data_q.push_back(win ? 16'(1 + k) : cur_def);
          exp_row_q.push_back(9'(r));
          exp_last_q.push_back(w == WPR - 1);
          if (win) k++;
        end
    exp_total = nsub * NR * WPR;
    exp_up = k;
  endtask

  always @(negedge clk) begin
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    if (bus.out_ready === 1'bx) bus.out_ready = 1'b1;
    bus.in_valid = ($urandom_range(0, 99) < valid_pct);
    bus.in_data  = bus.in_valid ? up_val : 16'($urandom);
    #1;
    if (!chk_en || !rst_n) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_word", 32'({bus.out_rowadd, bus.out_last, bus.out_data}), 32'(hold_pkt));
      end
      if (bus.in_ready) in_ready_seen = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        up_hs++;
        up_val++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_data_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_word actual=%0h required=none", bus.out_data);
        end else begin
          chk("word_data", 32'(bus.out_data), 32'(exp_data_q[0]));
          chk("word_row", 32'(bus.out_rowadd), 32'(exp_row_q[0]));
          chk("word_last", 32'(bus.out_last), 32'(exp_last_q[0]));
          void'(exp_data_q.pop_front()); void'(exp_row_q.pop_front()); void'(exp_last_q.pop_front());
          out_cnt++;
        end
      end
      if (frame_done) done_cnt++;
      hold_q   = bus.out_valid && !bus.out_ready;
      hold_pkt = {bus.out_rowadd, bus.out_last, bus.out_data};
    end
  end

  task automatic drive_cfg();
    cfg_row_t = cur_t; cfg_row_b = cur_b; cfg_num_sub = cur_ns; mstream_default = cur_def;
`ifdef MASK_INVERT_EN
    cfg_invert = cur_inv;
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_rowadd", 32'(bus.out_rowadd), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
  endtask

  task automatic run_frame(input int rmode, input int vpct, input bit mid, input bit sod);
    int unsigned cyc;
    bit got;
    up_hs = 0; out_cnt = 0; done_cnt = 0; in_ready_seen = 1'b0; up_val = 16'h0001;
    ready_mode = rmode; valid_pct = vpct; chk_en = 1'b1;
    drive_cfg();
    pulse_start();
    if (mid) begin
      cfg_row_t = cur_t + 9'd3; mstream_default = ~cur_def; cfg_num_sub = cur_ns + 8'd1;
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    cyc = 0; got = 1'b0;
    while (!got && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (frame_done) got = 1'b1;
    end
    chk("frame_done_seen", 32'(got), 32'd1);
    if (sod) begin
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); #2;
        chk("start_on_done_ignored", 32'(busy), 0);
      end
    end else begin
      repeat (3) @(negedge clk);
    end
    #2;
    chk("done_pulses", done_cnt, 1);
    chk("word_count", out_cnt, exp_total);
    chk("model_drained", exp_data_q.size(), 0);
    chk("upstream_handshakes", up_hs, exp_up);
    chk("busy_after_frame", 32'(busy), 0);
  endtask

  initial begin
    int unsigned cyc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;

    // Basic window, always-ready sink.
    cur_t = 9'd2; cur_b = 9'd5; cur_ns = 8'd1; cur_def = 16'hAAAA; cur_inv = 1'b0;
    build_frame();
    chk("model_total", exp_total, 16);
    chk("model_up", exp_up, 4);
    chk("model_row0", 32'(exp_data_q[0]), 32'h0000AAAA);
    chk("model_row3_w0", 32'(exp_data_q[6]), 32'h00000001);
    chk("model_row4_w1", 32'(exp_data_q[9]), 32'h00000004);
    chk("model_row5_w0", 32'(exp_data_q[10]), 32'h0000AAAA);
    run_frame(0, 100, 1'b0, 1'b0);

    // Toggling sink, then random sink with upstream underflow.
    build_frame(); run_frame(1, 100, 1'b0, 1'b0);
    build_frame(); run_frame(2, 60, 1'b0, 1'b0);

    // Empty window across two subframes; start coinciding with frame_done.
    cur_t = 9'd4; cur_b = 9'd5; cur_ns = 8'd2; cur_def = 16'h5A5A;
    build_frame();
    chk("model_empty_total", exp_total, 32);
    chk("model_empty_up", exp_up, 0);
    run_frame(2, 80, 1'b0, 1'b1);
    chk("empty_in_ready_never", 32'(in_ready_seen), 0);

    // Config changes and a stray start during the frame.
    cur_t = 9'd2; cur_b = 9'd5; cur_ns = 8'd1; cur_def = 16'hAAAA;
    build_frame(); run_frame(0, 100, 1'b1, 1'b0);

    // Asynchronous reset in the middle of row 5.
    build_frame();
    up_hs = 0; up_val = 16'h0001; ready_mode = 0; valid_pct = 100; chk_en = 1'b1;
    drive_cfg(); pulse_start();
    cyc = 0;
    while (!(bus.out_valid && bus.out_rowadd == 9'd5 && bus.out_last) && cyc < 500) begin
      @(negedge clk); #2; cyc++;
    end
    chk("reach_row5", 32'(cyc < 500), 32'd1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;
    build_frame(); run_frame(0, 100, 1'b0, 1'b0);

    // Random configurations, including num_sub = 0.
    for (int i = 0; i < 4; i++) begin
      cur_t = 9'($urandom_range(0, 8)); cur_b = 9'($urandom_range(0, 9));
      cur_ns = 8'($urandom_range(0, 2)); cur_def = 16'($urandom);
      build_frame(); run_frame(2, 50 + 10 * i, 1'b0, 1'b0);
    end

`ifdef MASK_INVERT_EN
    cur_t = 9'd2; cur_b = 9'd5; cur_ns = 8'd1; cur_def = 16'hAAAA; cur_inv = 1'b1;
    build_frame();
    chk("model_inv_up", exp_up, 12);
    chk("model_inv_row3", 32'(exp_data_q[6]), 32'h0000AAAA);
    run_frame(2, 70, 1'b0, 1'b0);
    cur_inv = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
